// File: rtl/triangle_projection_scheduler_if.sv
// triangle_projection_scheduler_if: mesh, projection-unit and output bundle.
// master is the scheduler side, slave the surrounding fabric.
interface triangle_projection_scheduler_if #(
  parameter int COORD_WIDTH = 32,
  parameter int ADDR_WIDTH  = 10
);
  logic                      frame_start;
  logic [ADDR_WIDTH-1:0]     tri_count;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [9*COORD_WIDTH-1:0]  mem_data;
  logic                      proj_start;
  logic [9*COORD_WIDTH-1:0]  proj_verts;
  logic                      proj_busy;
  logic                      proj_done;
  logic                      proj_valid;
  logic [1:0]                proj_status;
  logic [12*COORD_WIDTH-1:0] proj_result;
  logic [12*COORD_WIDTH-1:0] out_tri;
  logic                      out_valid;
  logic                      out_ready;
  logic                      busy;
  logic                      frame_done;
  logic [ADDR_WIDTH-1:0]     culled_count;
  logic [ADDR_WIDTH-1:0]     error_count;

  modport master (
    input  frame_start, tri_count, mem_data,
    input  proj_busy, proj_done, proj_valid,
    input  proj_status, proj_result, out_ready,
    output mem_addr, proj_start, proj_verts,
    output out_tri, out_valid, busy, frame_done,
    output culled_count, error_count
  );

  modport slave (
    output frame_start, tri_count, mem_data,
    output proj_busy, proj_done, proj_valid,
    output proj_status, proj_result, out_ready,
    input  mem_addr, proj_start, proj_verts,
    input  out_tri, out_valid, busy, frame_done,
    input  culled_count, error_count
  );
endinterface

// File: rtl/triangle_projection_scheduler.sv
// triangle_projection_scheduler: walks mesh memory, issues projection jobs.
// Drop counters are built only when TRI_SCHED_STATS_EN is defined.
module triangle_projection_scheduler #(
  parameter int COORD_WIDTH  = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input logic clk_in,
  input logic rst_in,
  triangle_projection_scheduler_if.master bus
);
  localparam int RW = 12*COORD_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(READ_LATENCY+1);
  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE, WAIT, COLLECT, FINISH
  } state_t;

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] idx, cnt;
  logic [LW-1:0]         lat;
  logic [RW-1:0]         res;
  logic                  res_valid;
  logic [1:0]            res_status;
  logic [RW-1:0]         fifo [FIFO_DEPTH];
  logic [PW:0]           wr_ptr, rd_ptr;
  logic full, empty, push, pop;
  logic last, fetch_done, advance;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop   = !empty && bus.out_ready;
  assign last  = ({1'b0, idx} + (ADDR_WIDTH+1)'(1)) ==
                 {1'b0, cnt};
  assign fetch_done = (state == FETCH) &&
                      (lat == LW'(READ_LATENCY));

  always_comb begin
    state_n = state;
    advance = 1'b0;
    push    = 1'b0;
    unique case (state)
      IDLE:
        if (bus.frame_start)
          state_n = (bus.tri_count == '0) ? FINISH : FETCH;
      FETCH:
        if (fetch_done) state_n = ISSUE;
      ISSUE:
        if (!bus.proj_busy && !bus.proj_done) state_n = WAIT;
      WAIT:
        if (bus.proj_done) state_n = COLLECT;
      COLLECT: begin
        // a push into a full FIFO is fine when the head pops this cycle
        advance = !res_valid || !full || pop;
        push    = advance && res_valid;
        if (advance) state_n = last ? FINISH : FETCH;
      end
      FINISH:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      lat            <= '0;
      res            <= '0;
      res_valid      <= 1'b0;
      res_status     <= 2'd0;
      bus.mem_addr   <= '0;
      bus.proj_start <= 1'b0;
      bus.proj_verts <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= state_n;
      bus.proj_start <= (state == ISSUE) && (state_n == WAIT);
      bus.frame_done <= (state == FINISH);
      if ((state == FETCH) && !fetch_done)
        lat <= lat + LW'(1);
      else
        lat <= '0;
      if ((state == IDLE) && bus.frame_start) begin
        cnt      <= bus.tri_count;
        idx      <= '0;
        bus.busy <= 1'b1;
        if (bus.tri_count != '0) bus.mem_addr <= '0;
      end
      if (fetch_done) bus.proj_verts <= bus.mem_data;
      if ((state == WAIT) && bus.proj_done) begin
        res        <= bus.proj_result;
        res_valid  <= bus.proj_valid;
        res_status <= bus.proj_status;
      end
      if (advance) begin
        idx <= idx + ONE;
        if (!last) bus.mem_addr <= idx + ONE;
      end
      if (state == FINISH) bus.busy <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo[wr_ptr[PW-1:0]] <= res;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  assign bus.out_valid = !empty;
  assign bus.out_tri   = empty ? '0 : fifo[rd_ptr[PW-1:0]];

`ifdef TRI_SCHED_STATS_EN
  logic [ADDR_WIDTH-1:0] culled, errors;

  always_ff @(posedge clk_in) begin
    if (rst_in || ((state == IDLE) && bus.frame_start)) begin
      culled <= '0;
      errors <= '0;
    end else if (advance && !res_valid) begin
      unique case (1'b1)
        (res_status == 2'd1):
          if (!(&culled)) culled <= culled + ONE;
        (res_status != 2'd1):
          if (!(&errors)) errors <= errors + ONE;
      endcase
    end
  end

  assign bus.culled_count = culled;
  assign bus.error_count  = errors;
`else
  logic unused_status;
  assign unused_status    = ^res_status;
  assign bus.culled_count = '0;
  assign bus.error_count  = '0;
`endif

endmodule

// File: tb/tb_triangle_projection_scheduler.sv
// tb_triangle_projection_scheduler: directed frames with a result scoreboard.
// Mesh memory and projection unit are behavioural models.
module tb_triangle_projection_scheduler;
  localparam int CW = 32;
  localparam int AW = 10;
  localparam int RL = 2;
  localparam int FD = 4;
  localparam int VW = 9*CW;
  localparam int RW = 12*CW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  triangle_projection_scheduler_if #(
    .COORD_WIDTH(CW), .ADDR_WIDTH(AW)
  ) bus ();

  triangle_projection_scheduler #(
    .COORD_WIDTH(CW), .ADDR_WIDTH(AW),
    .READ_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus.master)
  );

  int checks = 0;
  int errors = 0;
  int nstarts = 0;
  logic [RW-1:0] sb [$];

  int plat = 3;
  int busy_extra = 0;
  bit hold2 = 1'b0;
  bit busy2 = 1'b0;
  logic [1:0] stat_tab [16];

  function automatic logic [VW-1:0] verts_of(int a);
    logic [VW-1:0] v;
    for (int k = 0; k < 9; k++)
      v[k*CW +: CW] = CW'(a) + CW'(k * 32'h0101_0000);
    return v;
  endfunction

  function automatic logic [RW-1:0] res_of(logic [VW-1:0] v);
    logic [RW-1:0] r;
    for (int j = 0; j < 12; j++)
      r[j*CW +: CW] = v[(j%9)*CW +: CW] ^ CW'(32'hC0DE_0000 + j);
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkw(string name, logic [RW-1:0] act,
                      logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mesh memory with READ_LATENCY register stages
  logic [VW-1:0] stg [RL];
  always @(posedge clk) begin
    stg[0] <= verts_of(int'(bus.mem_addr));
    for (int i = 1; i < RL; i++) stg[i] <= stg[i-1];
  end
  assign bus.mem_data = stg[RL-1];

  initial begin : proj_model
    logic [VW-1:0] v;
    int a;
    bus.proj_busy   = 1'b0;
    bus.proj_done   = 1'b0;
    bus.proj_valid  = 1'b0;
    bus.proj_status = 2'd0;
    bus.proj_result = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.proj_start === 1'b1) begin
        v = bus.proj_verts;
        a = int'(v[CW-1:0]) & 15;
        bus.proj_busy = 1'b1;
        repeat (plat) @(posedge clk);
        #1;
        bus.proj_busy   = 1'b0;
        bus.proj_done   = 1'b1;
        bus.proj_result = res_of(v);
        bus.proj_status = stat_tab[a];
        bus.proj_valid  = (stat_tab[a] == 2'd0);
        @(posedge clk); #1;
        if (hold2) begin
          bus.proj_busy = busy2;
          @(posedge clk); #1;
        end
        bus.proj_done  = 1'b0;
        bus.proj_valid = 1'b0;
        bus.proj_busy  = 1'b0;
        if (busy_extra > 0) begin
          bus.proj_busy = 1'b1;
          repeat (busy_extra) @(posedge clk);
          #1;
          bus.proj_busy = 1'b0;
        end
      end
    end
  end

  logic pend_q = 1'b0;
  always @(posedge clk) pend_q <= bus.proj_busy | bus.proj_done;

  always @(negedge clk) begin
    if (bus.proj_start === 1'b1) begin
      nstarts++;
      chk("start_gate", int'(pend_q), 0);
    end
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_tri: got %0h expected none", bus.out_tri);
      end else begin
        chkw("out_tri", bus.out_tri, sb.pop_front());
      end
    end
  end

  task automatic expect_frame(int n);
    for (int a = 0; a < n; a++)
      if (stat_tab[a] == 2'd0) sb.push_back(res_of(verts_of(a)));
  endtask

  task automatic start_frame(int n);
    bus.tri_count   = AW'(n);
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_done(string name);
    int c = 0;
    while (bus.frame_done !== 1'b1 && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
    chk({name, "_frame_done"}, int'(bus.frame_done), 1);
    chk({name, "_busy_low"}, int'(bus.busy), 0);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, int'(bus.frame_done), 0);
  endtask

  task automatic wait_drain(string name);
    int c = 0;
    while (sb.size() != 0 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk({name, "_drain"}, sb.size(), 0);
  endtask

  task automatic chk_counts(string name, int cul, int err);
`ifdef TRI_SCHED_STATS_EN
    chk({name, "_culled"}, int'(bus.culled_count), cul);
    chk({name, "_errors"}, int'(bus.error_count), err);
`else
    chk({name, "_culled"}, int'(bus.culled_count), 0);
    chk({name, "_errors"}, int'(bus.error_count), 0);
    if (cul < 0 || err < 0) $display("bad count request");
`endif
  endtask

  task automatic chk_reset(string name);
    chk({name, "_mem_addr"}, int'(bus.mem_addr), 0);
    chk({name, "_proj_start"}, int'(bus.proj_start), 0);
    chk({name, "_busy"}, int'(bus.busy), 0);
    chk({name, "_frame_done"}, int'(bus.frame_done), 0);
    chk({name, "_out_valid"}, int'(bus.out_valid), 0);
    chk({name, "_culled"}, int'(bus.culled_count), 0);
    chk({name, "_errors"}, int'(bus.error_count), 0);
    chkw({name, "_proj_verts"}, RW'(bus.proj_verts), '0);
    chkw({name, "_out_tri"}, bus.out_tri, '0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c;
    int a0;
    rst = 1'b1;
    bus.frame_start = 1'b0;
    bus.tri_count   = '0;
    bus.out_ready   = 1'b0;
    foreach (stat_tab[i]) stat_tab[i] = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // three valid triangles, free-running consumer
    bus.out_ready = 1'b1;
    expect_frame(3);
    nstarts = 0;
    start_frame(3);
    chk("t1_busy", int'(bus.busy), 1);
    c = 0;
    while (bus.proj_start !== 1'b1 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("t1_start_lat", c, RL + 2);
    bus.tri_count   = AW'(9);
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    wait_done("t1");
    wait_drain("t1");
    chk("t1_starts", nstarts, 3);

    // mixed statuses: ok, cull, divide error, ok
    stat_tab[1] = 2'd1;
    stat_tab[2] = 2'd2;
    expect_frame(4);
    start_frame(4);
    wait_done("t2");
    wait_drain("t2");
    chk_counts("t2", 1, 1);
    stat_tab[1] = 2'd0;
    stat_tab[2] = 2'd0;

    // consumer stalled: FIFO fills and the fifth result is held
    bus.out_ready = 1'b0;
    plat = 2;
    expect_frame(6);
    nstarts = 0;
    start_frame(6);
    repeat (150) @(posedge clk);
    #1;
    chk("t3_starts_held", nstarts, 5);
    chk("t3_busy_held", int'(bus.busy), 1);
    chk("t3_out_valid", int'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    wait_done("t3");
    wait_drain("t3");
    chk("t3_starts", nstarts, 6);
    chk_counts("t3", 0, 0);

    // empty mesh
    a0 = int'(bus.mem_addr);
    nstarts = 0;
    start_frame(0);
    chk("t4_busy", int'(bus.busy), 1);
    chk("t4_done_early", int'(bus.frame_done), 0);
    @(posedge clk); #1;
    chk("t4_frame_done", int'(bus.frame_done), 1);
    chk("t4_busy_low", int'(bus.busy), 0);
    @(posedge clk); #1;
    chk("t4_done_pulse", int'(bus.frame_done), 0);
    chk("t4_mem_addr", int'(bus.mem_addr), a0);
    chk("t4_starts", nstarts, 0);

    // done held two cycles, busy high on the second and after
    hold2 = 1'b1;
    busy2 = 1'b1;
    busy_extra = 8;
    expect_frame(3);
    start_frame(3);
    wait_done("t5");
    wait_drain("t5");
    repeat (15) @(posedge clk);
    #1;
    chk("t5_no_extra", int'(bus.out_valid), 0);

    // reset while waiting on the third job with two results queued
    hold2 = 1'b0;
    busy2 = 1'b0;
    busy_extra = 0;
    plat = 6;
    bus.out_ready = 1'b0;
    expect_frame(4);
    nstarts = 0;
    start_frame(4);
    c = 0;
    while (nstarts < 3 && c < 500) begin
      @(posedge clk); #1;
      c++;
    end
    chk("t6_third_start", nstarts, 3);
    @(posedge clk); #1;
    chk("t6_queued", int'(bus.out_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset("t6_rst");
    sb.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    expect_frame(2);
    start_frame(2);
    wait_done("t6");
    wait_drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
